// File: rtl/main_mem_pkg.sv
// Shared definitions for the MIPS main memory: access-size encodings,
// burst-length decode and the default memory map.
package main_mem_pkg;

    typedef enum logic [1:0] {
        ACC_1W  = 2'b00,
        ACC_4W  = 2'b01,
        ACC_8W  = 2'b10,
        ACC_16W = 2'b11
    } acc_size_e;

    localparam logic [0:31]  DEFAULT_BASE_ADDR = 32'h8002_0000;
    localparam int unsigned  DEFAULT_MEM_WORDS = 262144;

    function automatic logic [4:0] burst_len(input logic [0:1] acc);
        logic [4:0] len;
        case (acc)
            ACC_1W:  len = 5'd1;
            ACC_4W:  len = 5'd4;
            ACC_8W:  len = 5'd8;
            ACC_16W: len = 5'd16;
            default: len = 5'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/main_mem_if.sv
// Request/response bus between a pipeline stage (master) and main memory (slave).
interface main_mem_if;

    logic [0:31] addr;
    logic [0:31] data_in;
    logic [0:31] data_out;
    logic [0:1]  acc_size;
    logic        wren;
    logic        busy;
    logic        enable;

    modport master (
        output addr, data_in, acc_size, wren, enable,
        input  data_out, busy
    );

    modport slave (
        input  addr, data_in, acc_size, wren, enable,
        output data_out, busy
    );

endinterface

// File: rtl/main_mem_array.sv
// Single-port synchronous word RAM with a resettable read register; the
// storage itself is never cleared so contents survive a reset.
module main_mem_array #(
    parameter  int MEM_WORDS = 262144,
    localparam int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic          rd_zero,
    input  logic [AW-1:0] idx,
    input  logic [0:31]   wdata,
    output logic [0:31]   rdata
);

    logic [0:31] mem_r [0:MEM_WORDS-1];
    logic [0:31] rdata_r;

    // Storage write port.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[idx] <= wdata;
        end
    end

    // Read register; rd_zero substitutes zero for beats outside the array.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata_r <= 32'h0000_0000;
        end else if (rd_en) begin
            rdata_r <= rd_zero ? 32'h0000_0000 : mem_r[idx];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/main_mem.sv
// MIPS main memory: burst control FSM, byte-address to word-index translation
// and range checking in front of a single-port word RAM.
module main_mem
    import main_mem_pkg::*;
#(
    parameter logic [0:31] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          MEM_WORDS = 262144
) (
    input  logic      clock,
    input  logic      reset_n,
    main_mem_if.slave bus
);

    localparam int         AW    = $clog2(MEM_WORDS);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic [0:0]  state_r;
    logic        busy_r;
    logic [3:0]  cnt_r;
    logic [4:0]  len_r;
    logic        wren_r;
    logic [31:0] idx_r;

    logic [31:0] req_idx_s;
    logic [4:0]  req_len_s;
    logic [31:0] beat_idx_s;
    logic        beat_s;
    logic        beat_wren_s;
    logic        in_range_s;
    logic        last_s;

    // Addresses below BASE_ADDR wrap to huge indices and fail the range check.
    assign req_idx_s = (bus.addr - BASE_ADDR) >> 2;
    assign req_len_s = burst_len(bus.acc_size);

    // Select the request fields in IDLE and the latched burst fields in BURST.
    always_comb begin
        beat_s      = 1'b0;
        beat_wren_s = 1'b0;
        beat_idx_s  = 32'h0000_0000;
        if (state_r == IDLE) begin
            beat_s      = bus.enable;
            beat_wren_s = bus.wren;
            beat_idx_s  = req_idx_s;
        end else begin
            beat_s      = bus.enable;
            beat_wren_s = wren_r;
            beat_idx_s  = idx_r;
        end
        in_range_s = (beat_idx_s < 32'(MEM_WORDS));
        last_s     = ({1'b0, cnt_r} == (len_r - 5'd1));
    end

    // Burst FSM: cnt_r and idx_r always describe the next beat to perform.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= 4'd0;
            len_r   <= 5'd1;
            wren_r  <= 1'b0;
            idx_r   <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.enable && (req_len_s > 5'd1)) begin
                        state_r <= BURST;
                        busy_r  <= 1'b1;
                        cnt_r   <= 4'd1;
                        len_r   <= req_len_s;
                        wren_r  <= bus.wren;
                        idx_r   <= req_idx_s + 32'd1;
                    end
                end
                BURST: begin
                    if (!bus.enable || last_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= 4'd0;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                        idx_r <= idx_r + 32'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;

    main_mem_array #(
        .MEM_WORDS (MEM_WORDS)
    ) u_array (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (beat_s && beat_wren_s && in_range_s),
        .rd_en   (beat_s && !beat_wren_s),
        .rd_zero (!in_range_s),
        .idx     (beat_idx_s[AW-1:0]),
        .wdata   (bus.data_in),
        .rdata   (bus.data_out)
    );

endmodule

// File: tb/tb_main_mem.sv
// Scoreboard bench for main_mem: a reference word map predicts every read
// beat, and busy / hold / reset behaviour is checked edge by edge.
module tb_main_mem;

    localparam logic [31:0] BASE  = 32'h8002_0000;
    localparam int          WORDS = 262144;

    typedef struct {
        int          due;
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] last_rd = 32'h0000_0000;
    exp_t        sb[$];
    logic [31:0] wq[$];
    logic [31:0] ref_mem [int unsigned];

    always #5 clock = ~clock;

    main_mem_if bus ();

    main_mem #(
        .BASE_ADDR (BASE),
        .MEM_WORDS (WORDS)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock edge, then retire every read beat due at this edge.
    task automatic tick();
        exp_t e;
        @(posedge clock);
        cyc++;
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check_val(e.tag, bus.data_out, e.val);
            last_rd = e.val;
        end
    endtask

    task automatic idle(input int n);
        bus.enable = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            check_val("hold_dout", bus.data_out, last_rd);
            check_val("idle_busy", {31'h0, bus.busy}, 32'h0);
        end
    endtask

    // Drive one transaction. At beat 'cut' the burst is aborted, either by
    // dropping enable or (cut_rst) by an asynchronous reset.
    task automatic run_burst(input logic [31:0] a, input logic w, input logic [1:0] acc,
                             input int cut, input bit cut_rst);
        int          len;
        logic [31:0] idx;
        logic [31:0] cur;
        logic [31:0] d;
        len = (acc == 2'b00) ? 1 : (2 << acc);
        idx = (a - BASE) >> 2;
        for (int k = 0; k < len; k++) begin
            if (k == cut) begin
                bus.enable = 1'b0;
                if (cut_rst) begin
                    reset_n = 1'b0;
                    #1;
                    check_val("rst_dout", bus.data_out, 32'h0);
                    check_val("rst_busy", {31'h0, bus.busy}, 32'h0);
                    sb.delete();
                    last_rd = 32'h0;
                    @(negedge clock);
                    reset_n = 1'b1;
                end else begin
                    tick();
                    check_val("abort_busy", {31'h0, bus.busy}, 32'h0);
                end
                return;
            end
            bus.enable = 1'b1;
            if (k == 0) begin
                bus.addr     = a;
                bus.wren     = w;
                bus.acc_size = acc;
            end else begin
                bus.addr     = $urandom;
                bus.wren     = ~w;
                bus.acc_size = 2'($urandom);
            end
            cur = idx + 32'(k);
            if (w) begin
                d = (wq.size() > 0) ? wq.pop_front() : $urandom;
                if (cur < 32'(WORDS)) ref_mem[cur] = d;
            end else begin
                d = $urandom;
                sb.push_back('{due: cyc + 1, tag: "rd_data",
                               val: (cur < 32'(WORDS)) ? ref_mem[cur] : 32'h0});
            end
            bus.data_in = d;
            tick();
            check_val("busy", {31'h0, bus.busy}, (k < len - 1) ? 32'h1 : 32'h0);
        end
        bus.enable = 1'b0;
    endtask

    initial begin
        bus.enable   = 1'b0;
        bus.wren     = 1'b0;
        bus.addr     = 32'h0;
        bus.data_in  = 32'h0;
        bus.acc_size = 2'b00;
        #12;
        check_val("reset_dout", bus.data_out, 32'h0);
        check_val("reset_busy", {31'h0, bus.busy}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        idle(1);

        // single write / read
        wq.push_back(32'h55CC_55CC);
        run_burst(32'h8002_0000, 1'b1, 2'b00, -1, 1'b0);
        run_burst(32'h8002_0000, 1'b0, 2'b00, -1, 1'b0);

        // 4-word burst write, overlapping 4-word read
        wq.push_back(32'h55CC_55CD);
        wq.push_back(32'h55CC_55CE);
        wq.push_back(32'h55CC_55CF);
        wq.push_back(32'h55CC_55C1);
        run_burst(32'h8002_0004, 1'b1, 2'b01, -1, 1'b0);
        run_burst(32'h8002_0000, 1'b0, 2'b01, -1, 1'b0);
        idle(3);

        // 16-word incrementing burst
        for (int i = 0; i < 16; i++) wq.push_back(32'h1000_0000 + 32'(i));
        run_burst(32'h8002_0100, 1'b1, 2'b11, -1, 1'b0);
        run_burst(32'h8002_0100, 1'b0, 2'b11, -1, 1'b0);
        idle(2);

        // out of range: index of 0x8000_0000 aliases 0x8010_0000 in the low bits
        wq.push_back(32'hA5A5_0001);
        run_burst(32'h8010_0000, 1'b1, 2'b00, -1, 1'b0);
        wq.push_back(32'hDEAD_BEEF);
        run_burst(32'h8000_0000, 1'b1, 2'b00, -1, 1'b0);
        run_burst(32'h8000_0000, 1'b0, 2'b00, -1, 1'b0);
        run_burst(32'h8010_0000, 1'b0, 2'b00, -1, 1'b0);

        // burst straddling the top of memory
        for (int i = 0; i < 4; i++) wq.push_back(32'h7700_0000 + 32'(i));
        run_burst(32'h8011_FFF8, 1'b1, 2'b01, -1, 1'b0);
        run_burst(32'h8011_FFF8, 1'b0, 2'b01, -1, 1'b0);
        idle(1);

        // enable dropped after beat 1 of an 8-word write
        for (int i = 0; i < 8; i++) wq.push_back(32'h3300_0000 + 32'(i));
        run_burst(32'h8002_0200, 1'b1, 2'b10, -1, 1'b0);
        wq.push_back(32'hC0DE_0000);
        wq.push_back(32'hC0DE_0001);
        run_burst(32'h8002_0200, 1'b1, 2'b10, 2, 1'b0);
        idle(1);
        run_burst(32'h8002_0200, 1'b0, 2'b10, -1, 1'b0);

        // reset in the middle of a 16-word read; memory must survive
        run_burst(32'h8002_0100, 1'b0, 2'b11, 5, 1'b1);
        idle(2);
        run_burst(32'h8002_0100, 1'b0, 2'b01, -1, 1'b0);
        run_burst(32'h8002_0000, 1'b0, 2'b00, -1, 1'b0);
        idle(2);

        check_val("sb_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
